led_anim_sequencer: RTL
=======================

// Module: led_anim_sequencer
// PURPOSE
//   Steps the 7-bit frame index of an LED pattern decoder ROM (7-bit frame in,
//   7-bit active-low LED word out) at a programmable rate. Selects one of NPAT
//   pattern ROMs, supports looped and one-shot playback, and registers the ROM
//   word onto the LED pins. Sits between the board I/O (buttons, switches) and
//   the pattern decoder bank.
// PARAMETERS
//   DIV_W   24   width of the frame-period divider input
//   FRAMES  128  frames per pattern; frame index runs 0..FRAMES-1 (7-bit)
//   NPAT    4    number of selectable pattern ROMs; PAT_W = $clog2(NPAT)
// PORTS
//   clk       in   1      system clock
//   rst       in   1      reset; synchronous, active-high
//   start     in   1      begin playback (single-cycle pulse)
//   stop      in   1      abort playback (single-cycle pulse)
//   one_shot  in   1      1 = play once then stop; 0 = loop
//   pat_sel   in   PAT_W  requested pattern
//   div       in   DIV_W  frame period minus 1, in clk cycles
//   rom_data  in   7      active-low LED word from selected decoder (comb.)
//   frame     out  7      frame index to decoder ROMs (registered)
//   pat       out  PAT_W  active pattern, drives ROM mux (registered)
//   led_n     out  7      active-low LED drive (registered)
//   busy      out  1      1 while in RUN
//   done      out  1      one-cycle pulse at end of a one-shot play
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, frame=0, pat=0, prescaler=0,
//   shot=0, led_n=7'h7F (all off), busy=0, done=0. Reset mid-play aborts with no done.
// - States: IDLE, RUN.
//   IDLE: led_n=7'h7F, frame=0. start=1 -> RUN; same edge: pat<=pat_sel,
//     shot<=one_shot, prescaler<=0, frame<=0.
//   RUN: prescaler counts up each cycle; tick when prescaler>=div
//     (>= so a lowered div never overruns); on tick prescaler<=0, frame advances.
//     div is sampled live; div=0 -> tick every cycle. start in RUN ignored.
// - End of sequence = tick while frame==FRAMES-1:
//     shot=1 -> done=1 for one cycle, state<=IDLE, frame<=0, led_n<=7'h7F.
//     shot=0 -> frame<=0, pat<=pat_sel (pattern changes only here, never mid-sequence).
// - stop=1 in RUN -> IDLE on that edge; stop beats a coincident tick/end; done=0.
//   start and stop together in IDLE: stay IDLE.
// - led_n <= rom_data every cycle in RUN: one cycle latency from frame/pat to led_n.
// - busy = (state==RUN), registered with state.
// - Prescaler is DIV_W bits, no wrap possible given the >= compare.
// CONFIGURATION
//   LED_ANIM_PINGPONG_EN defined: direction register dir (reset/start = up).
//     Up: tick at FRAMES-1 -> dir<=down, frame<=FRAMES-2.
//     Down: tick at frame>0 -> frame-1; tick at frame 0 = end of sequence
//     (one-shot/loop rules above apply, dir<=up).
//     Sequence is 0..127..0 = 255 frames.
//   Not defined: ascending only, no dir register; sequence is 128 frames.
// TESTING
// 1 rst held 3 cycles mid-RUN -> next cycle led_n=7'h7F, frame=0, busy=0, done=0.
// 2 loop, div=3, start -> frame steps every 4 clk; 127->0 wrap at cycle 512;
//   led_n equals ROM word of previous cycle's frame.
// 3 one_shot=1, div=0 -> frame 0..127, done high exactly 1 cycle on tick 128,
//   then busy=0, led_n=7'h7F.
// 4 stop pulse at frame=50 coincident with tick -> IDLE next edge, frame=0, done=0.
// 5 loop, pat_sel 0->2 at frame 10 -> pat stays 0 through frame 127, pat=2 from wrap.
// 6 LED_ANIM_PINGPONG_EN, one_shot=1, div=0 -> frames 0..127,126..0; done on tick 255.

Source files
------------

// File: rtl/led_anim_sequencer.sv
// Frame stepper for an LED pattern decoder bank: programmable frame rate, pattern select,
// looped or one-shot playback. Define LED_ANIM_PINGPONG_EN for up/down (ping-pong) playback.
module led_anim_sequencer #(
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned FRAMES = 128,
  parameter int unsigned NPAT   = 4,
  localparam int unsigned PAT_W = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [PAT_W-1:0] pat_sel,
  input  logic [DIV_W-1:0] div,
  input  logic [6:0]       rom_data,
  output logic [6:0]       frame,
  output logic [PAT_W-1:0] pat,
  output logic [6:0]       led_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FRAME_W = 7;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
  localparam logic [6:0]         LED_OFF    = 7'h7F;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               shot_q, shot_d;
  logic [6:0]         led_n_q, led_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_c;
  logic               seq_end_c;

`ifdef LED_ANIM_PINGPONG_EN
  logic dir_q, dir_d;  // 0 = ascending, 1 = descending
  assign seq_end_c = dir_q && (frame_q == '0);
`else
  assign seq_end_c = (frame_q == LAST_FRAME);
`endif

  // >= keeps a lowered div from letting the prescaler run past it
  assign tick_c = (presc_q >= div);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pat_d   = pat_q;
    presc_d = presc_q;
    shot_d  = shot_q;
    led_n_d = LED_OFF;
    done_d  = 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        frame_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          pat_d   = pat_sel;
          shot_d  = one_shot;
          presc_d = '0;
`ifdef LED_ANIM_PINGPONG_EN
          dir_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          frame_d = '0;
        end else begin
          led_n_d = rom_data;
          presc_d = tick_c ? '0 : presc_q + DIV_W'(1);
          if (tick_c) begin
            if (seq_end_c) begin
              frame_d = '0;
`ifdef LED_ANIM_PINGPONG_EN
              dir_d   = 1'b0;
`endif
              if (shot_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                led_n_d = LED_OFF;
              end else begin
                pat_d = pat_sel;
              end
            end else begin
`ifdef LED_ANIM_PINGPONG_EN
              if (dir_q) begin
                frame_d = frame_q - FRAME_W'(1);
              end else if (frame_q == LAST_FRAME) begin
                dir_d   = 1'b1;
                frame_d = frame_q - FRAME_W'(1);
              end else begin
                frame_d = frame_q + FRAME_W'(1);
              end
`else
              frame_d = frame_q + FRAME_W'(1);
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      pat_q   <= '0;
      presc_q <= '0;
      shot_q  <= 1'b0;
      led_n_q <= LED_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      presc_q <= presc_d;
      shot_q  <= shot_d;
      led_n_q <= led_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LED_ANIM_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign frame = frame_q;
  assign pat   = pat_q;
  assign led_n = led_n_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
